multiplexador_funcionalidade_n: RTL and testbench



---
 rtl/funcionalidade_pkg.sv | 22 ++
 rtl/filtro_persistencia.sv | 62 ++++++
 rtl/multiplexador_funcionalidade_n.sv | 77 +++++++
 tb/tb_multiplexador_funcionalidade_n.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/funcionalidade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : funcionalidade_pkg
//  Description : Shared mode encodings and counter-width helper for the
//                functionality multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package funcionalidade_pkg;

    localparam logic MODO_OU = 1'b0;
    localparam logic MODO_E  = 1'b1;

    // Counter must represent 0..HOLD; guard against degenerate HOLD values.
    function automatic int largura_cnt(input int hold);
        if (hold < 1) begin
            return 1;
        end
        return $clog2(hold + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_persistencia.sv
`default_nettype none
// ============================================================================
//  Module      : filtro_persistencia
//  Description : Persistence filter; q follows d only after d has differed
//                from q for HOLD consecutive cycles, with a change pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module filtro_persistencia
    import funcionalidade_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic pulso
);

    localparam int CNT_W = largura_cnt(HOLD);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             pulso_q, pulso_d;

    always_comb begin
        cnt_d   = cnt_q;
        q_d     = q_q;
        pulso_d = 1'b0;
        // A clear restarts qualification and freezes q, even on the qualifying cycle.
        if (clr) begin
            cnt_d = '0;
        end else if (d == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            q_d     = d;
            pulso_d = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            q_q     <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            pulso_q <= pulso_d;
        end
    end

    assign q     = q_q;
    assign pulso = pulso_q;

endmodule
`default_nettype wire

// File: rtl/multiplexador_funcionalidade_n.sv
`default_nettype none
// ============================================================================
//  Module      : multiplexador_funcionalidade_n
//  Description : N-channel masked OR/AND combiner with programmable mask/mode
//                registers and a persistence-filtered registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplexador_funcionalidade_n
    import funcionalidade_pkg::*;
#(
    parameter int           N          = 2,
    parameter int           HOLD       = 4,
    parameter logic [N-1:0] RESET_MASK = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] mask_in,
    input  logic         modo_in,
    input  logic [N-1:0] entradas,
    output logic         S,
    output logic         mudou,
    output logic [N-1:0] mask_q,
    output logic         modo_q
);

    logic [N-1:0] mask_r_q, mask_r_d;
    logic         modo_r_q, modo_r_d;
    logic         bruto;

    always_comb begin
        mask_r_d = mask_r_q;
        modo_r_d = modo_r_q;
        if (load) begin
            mask_r_d = mask_in;
            modo_r_d = modo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r_q <= RESET_MASK;
            modo_r_q <= MODO_OU;
        end else begin
            mask_r_q <= mask_r_d;
            modo_r_q <= modo_r_d;
        end
    end

    // An empty mask yields 0 in both modes; unmasked channels count as 1 for AND.
    always_comb begin
        bruto = 1'b0;
        if (mask_r_q != '0) begin
            if (modo_r_q == MODO_E) begin
                bruto = &(entradas | ~mask_r_q);
            end else begin
                bruto = |(mask_r_q & entradas);
            end
        end
    end

    filtro_persistencia #(
        .HOLD (HOLD)
    ) u_filtro (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .d     (bruto),
        .q     (S),
        .pulso (mudou)
    );

    assign mask_q = mask_r_q;
    assign modo_q = modo_r_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplexador_funcionalidade_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplexador_funcionalidade_n
//  Description : Self-checking bench: directed vector table plus randomized
//                traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexador_funcionalidade_n;

    localparam int N    = 2;
    localparam int HOLD = 3;

    logic         clk = 1'b0;
    logic         reset, load, modo_in;
    logic [N-1:0] mask_in, entradas;
    logic         S, mudou, modo_q;
    logic [N-1:0] mask_q;

    int checks = 0;
    int errors = 0;

    multiplexador_funcionalidade_n #(
        .N          (N),
        .HOLD       (HOLD),
        .RESET_MASK ('0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .mask_in  (mask_in),
        .modo_in  (modo_in),
        .entradas (entradas),
        .S        (S),
        .mudou    (mudou),
        .mask_q   (mask_q),
        .modo_q   (modo_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [N-1:0] mk_in;
        logic         md_in;
        logic [N-1:0] ent;
        logic         s;
        logic         m;
        logic [N-1:0] mk;
        logic         md;
    } vec_t;

    vec_t tab[$];

    // Behavioural model: mismatch history since the last restart.
    logic [N-1:0] m_mask;
    logic         m_modo, m_s, m_mudou;
    bit           hist[$];

    function automatic logic ref_bruto(logic [N-1:0] mk, logic md, logic [N-1:0] e);
        logic any_on = 1'b0;
        logic all_on = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (mk[i]) begin
                any_on = any_on | e[i];
                all_on = all_on & e[i];
            end
        end
        if (mk == '0) return 1'b0;
        return md ? all_on : any_on;
    endfunction

    task automatic model_step();
        logic b;
        if (reset) begin
            m_mask = '0; m_modo = 1'b0; m_s = 1'b0; m_mudou = 1'b0;
            hist.delete();
        end else begin
            b = ref_bruto(m_mask, m_modo, entradas);
            m_mudou = 1'b0;
            if (load) begin
                m_mask = mask_in; m_modo = modo_in;
                hist.delete();
            end else if (b == m_s) begin
                hist.delete();
            end else begin
                hist.push_back(1'b1);
                if (hist.size() == HOLD) begin
                    m_s = b; m_mudou = 1'b1;
                    hist.delete();
                end
            end
        end
    endtask

    task automatic chk(string nome, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic l, logic [N-1:0] mk, logic md, logic [N-1:0] e);
        @(negedge clk);
        reset = r; load = l; mask_in = mk; modo_in = md; entradas = e;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(logic r, logic l, logic [N-1:0] mk, logic md, logic [N-1:0] e,
                       logic s, logic m, logic [N-1:0] emk, logic emd);
        vec_t v;
        v.rst = r; v.ld = l; v.mk_in = mk; v.md_in = md; v.ent = e;
        v.s = s; v.m = m; v.mk = emk; v.md = emd;
        tab.push_back(v);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; mask_in = '0; modo_in = 1'b0; entradas = '0;
        m_mask = '0; m_modo = 1'b0; m_s = 1'b0; m_mudou = 1'b0;

        //   rst ld  mask  md ent   S  m  mask  md
        add(1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0);
        add(0, 1, 2'b11, 0, 2'b01, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b01, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b01, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b01, 1, 1, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b01, 1, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 1, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 1, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 0);
        // two-cycle glitch is rejected
        add(0, 0, 2'b00, 0, 2'b10, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b10, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 0);
        add(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b11, 0);
        // AND mode
        add(0, 1, 2'b11, 1, 2'b01, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b01, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b01, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b11, 1, 1, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b11, 1, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b10, 1, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b10, 1, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b10, 0, 1, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b10, 0, 0, 2'b11, 1);
        // load on the qualifying cycle wins, then full requalification
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b11, 1);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b11, 1);
        add(0, 1, 2'b01, 1, 2'b11, 0, 0, 2'b01, 1);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b01, 1);
        add(0, 0, 2'b00, 0, 2'b11, 0, 0, 2'b01, 1);
        add(0, 0, 2'b00, 0, 2'b11, 1, 1, 2'b01, 1);
        add(0, 0, 2'b00, 0, 2'b11, 1, 0, 2'b01, 1);
        // reset with load during qualification
        add(0, 0, 2'b00, 0, 2'b00, 1, 0, 2'b01, 1);
        add(0, 0, 2'b00, 0, 2'b00, 1, 0, 2'b01, 1);
        add(1, 1, 2'b10, 1, 2'b00, 0, 0, 2'b00, 0);
        add(0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0);

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].rst, tab[i].ld, tab[i].mk_in, tab[i].md_in, tab[i].ent);
            chk($sformatf("vec%0d_S", i),     32'(S),      32'(tab[i].s));
            chk($sformatf("vec%0d_mudou", i), 32'(mudou),  32'(tab[i].m));
            chk($sformatf("vec%0d_mask", i),  32'(mask_q), 32'(tab[i].mk));
            chk($sformatf("vec%0d_modo", i),  32'(modo_q), 32'(tab[i].md));
        end

        // Randomized traffic; inputs mostly held so qualification can complete.
        begin
            logic [N-1:0] e = '0;
            for (int c = 0; c < 600; c++) begin
                logic r, l;
                r = ($urandom_range(0, 59) == 0);
                l = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0) e = N'($urandom);
                drive(r, l, N'($urandom), 1'($urandom), e);
                chk($sformatf("rnd%0d_S", c),     32'(S),      32'(m_s));
                chk($sformatf("rnd%0d_mudou", c), 32'(mudou),  32'(m_mudou));
                chk($sformatf("rnd%0d_mask", c),  32'(mask_q), 32'(m_mask));
                chk($sformatf("rnd%0d_modo", c),  32'(modo_q), 32'(m_modo));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
